fpu_issue_ctrl: RTL and testbench



---
 rtl/fpu_issue_ctrl_pkg.sv | 69 ++++++
 rtl/fpu_lat_lut.sv | 42 ++++
 rtl/fpu_issue_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fpu_issue_ctrl_pkg
//
// Shared definitions for the FP issue/complete sequencer:
//   - FOP* opcode encodings as seen by the floating-point ALU
//   - sequencer FSM state encodings
//   - default per-class latencies and the latency counter width
//   - sticky exception flag bit positions for the FCSR fflags view
// ---------------------------------------------------------------------------
package fpu_issue_ctrl_pkg;

  localparam int OP_W = 5;

  // FP ALU opcodes. Codes not listed here are undefined and are treated
  // as single-cycle miscellaneous operations by the sequencer.
  localparam logic [OP_W-1:0] FOPADD    = 5'd0;
  localparam logic [OP_W-1:0] FOPSUB    = 5'd1;
  localparam logic [OP_W-1:0] FOPMUL    = 5'd2;
  localparam logic [OP_W-1:0] FOPDIV    = 5'd3;
  localparam logic [OP_W-1:0] FOPSQRT   = 5'd4;
  localparam logic [OP_W-1:0] FOPABS    = 5'd5;
  localparam logic [OP_W-1:0] FOPNEG    = 5'd6;
  localparam logic [OP_W-1:0] FOPSGNJ   = 5'd7;
  localparam logic [OP_W-1:0] FOPSGNJN  = 5'd8;
  localparam logic [OP_W-1:0] FOPSGNJX  = 5'd9;
  localparam logic [OP_W-1:0] FOPCVTSW  = 5'd10;
  localparam logic [OP_W-1:0] FOPCVTWS  = 5'd11;
  localparam logic [OP_W-1:0] FOPCVTSWU = 5'd12;
  localparam logic [OP_W-1:0] FOPCVTWUS = 5'd13;
  localparam logic [OP_W-1:0] FOPCEQ    = 5'd14;
  localparam logic [OP_W-1:0] FOPCLT    = 5'd15;
  localparam logic [OP_W-1:0] FOPCLE    = 5'd16;
  localparam logic [OP_W-1:0] FOPMAX    = 5'd17;
  localparam logic [OP_W-1:0] FOPMIN    = 5'd18;

  // Default latencies (cycles the operands must be held stable).
  localparam int DEF_LAT_ADD  = 7;
  localparam int DEF_LAT_MUL  = 5;
  localparam int DEF_LAT_DIV  = 6;
  localparam int DEF_LAT_SQRT = 16;
  localparam int DEF_LAT_CVT  = 6;
  localparam int DEF_LAT_CMP  = 1;
  localparam int DEF_LAT_MISC = 1;
  localparam int DEF_CNT_W    = 5;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  // Bit positions inside the 3-bit sticky fflags vector {NV, OF, UF}.
  localparam int FLAG_NV = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_UF = 0;

  // Pack the ALU exception outputs into fflags order.
  function automatic logic [2:0] pack_flags(input logic nv, input logic of_,
                                            input logic uf);
    logic [2:0] f;
    f          = '0;
    f[FLAG_NV] = nv;
    f[FLAG_OF] = of_;
    f[FLAG_UF] = uf;
    return f;
  endfunction

endpackage : fpu_issue_ctrl_pkg

// File: rtl/fpu_lat_lut.sv
// ---------------------------------------------------------------------------
// fpu_lat_lut
//
// Purely combinational opcode -> latency decode. Kept as its own block so the
// same table can drive both the issue sequencer and any hazard/scoreboard
// logic that needs to know how long an FP op occupies the ALU.
//
// Ports:
//   iop   in   OP_W   FOP* opcode
//   olat  out  CNT_W  cycles the ALU needs with stable inputs
// ---------------------------------------------------------------------------
module fpu_lat_lut
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int LAT_ADD  = DEF_LAT_ADD,
  parameter int LAT_MUL  = DEF_LAT_MUL,
  parameter int LAT_DIV  = DEF_LAT_DIV,
  parameter int LAT_SQRT = DEF_LAT_SQRT,
  parameter int LAT_CVT  = DEF_LAT_CVT,
  parameter int LAT_CMP  = DEF_LAT_CMP,
  parameter int LAT_MISC = DEF_LAT_MISC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic [OP_W-1:0]  iop,
  output logic [CNT_W-1:0] olat
);

  always_comb begin
    olat = CNT_W'(LAT_MISC);
    case (iop)
      FOPADD, FOPSUB:                               olat = CNT_W'(LAT_ADD);
      FOPMUL:                                       olat = CNT_W'(LAT_MUL);
      FOPDIV:                                       olat = CNT_W'(LAT_DIV);
      FOPSQRT:                                      olat = CNT_W'(LAT_SQRT);
      FOPCVTSW, FOPCVTWS, FOPCVTSWU, FOPCVTWUS:     olat = CNT_W'(LAT_CVT);
      FOPCEQ, FOPCLT, FOPCLE, FOPMAX, FOPMIN:       olat = CNT_W'(LAT_CMP);
      // Sign-manipulation ops and undefined codes fall through to LAT_MISC.
      default:                                      olat = CNT_W'(LAT_MISC);
    endcase
  end

endmodule : fpu_lat_lut

// File: rtl/fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_issue_ctrl
//
// Issue/complete sequencer sitting in front of the pipelined FP ALU.
// Registers one operation (operands + opcode) so the ALU sees stable inputs,
// counts down the opcode latency, then captures result, compare bit and
// exception flags. Keeps the sticky fflags {NV, OF, UF} for the FCSR.
//
// Ports:
//   iclock, ireset             clock, asynchronous active-high reset
//   istart, iop, ia, ib        issue request (sampled only while oready=1)
//   iclrflags                  clear sticky fflags on the next edge
//   odataa, odatab, ocontrol   registered operands/opcode to the ALU
//   iresult, icompresult       ALU result and compare bit
//   inan, izero, ioverflow,
//   iunderflow                 ALU exception flags
//   oready, obusy, odone       handshake / status (odone is a 1-cycle pulse)
//   oresult, ocomp             captured result/compare, held until next done
//   offlags                    sticky {NV, OF, UF}
//
// Timing: accept on edge E0, odone is high in the cycle after E(LAT+1), the
// sequencer is back in IDLE after E(LAT+2) and can accept on E(LAT+3).
// ---------------------------------------------------------------------------
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int LAT_ADD  = DEF_LAT_ADD,
  parameter int LAT_MUL  = DEF_LAT_MUL,
  parameter int LAT_DIV  = DEF_LAT_DIV,
  parameter int LAT_SQRT = DEF_LAT_SQRT,
  parameter int LAT_CVT  = DEF_LAT_CVT,
  parameter int LAT_CMP  = DEF_LAT_CMP,
  parameter int LAT_MISC = DEF_LAT_MISC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic            iclock,
  input  logic            ireset,
  input  logic            istart,
  input  logic [OP_W-1:0] iop,
  input  logic [31:0]     ia,
  input  logic [31:0]     ib,
  input  logic            iclrflags,
  output logic [31:0]     odataa,
  output logic [31:0]     odatab,
  output logic [OP_W-1:0] ocontrol,
  input  logic [31:0]     iresult,
  input  logic            inan,
  input  logic            izero,
  input  logic            ioverflow,
  input  logic            iunderflow,
  input  logic            icompresult,
  output logic            oready,
  output logic            obusy,
  output logic            odone,
  output logic [31:0]     oresult,
  output logic            ocomp,
  output logic [2:0]      offlags
);

  fsm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lat;
  logic [31:0]      dataa_q, dataa_d;
  logic [31:0]      datab_q, datab_d;
  logic [OP_W-1:0]  ctrl_q, ctrl_d;
  logic [31:0]      result_q, result_d;
  logic             comp_q, comp_d;
  logic [2:0]       flags_q, flags_d;

  logic accept;   // IDLE and a request present on this edge
  logic capture;  // last BUSY cycle: ALU outputs are valid now
  logic retire;   // DONE cycle: return to IDLE on this edge

  // The zero flag is neither sticky nor exported; it is deliberately dropped.
  logic izero_unused;
  assign izero_unused = izero;

  fpu_lat_lut #(
    .LAT_ADD  (LAT_ADD),
    .LAT_MUL  (LAT_MUL),
    .LAT_DIV  (LAT_DIV),
    .LAT_SQRT (LAT_SQRT),
    .LAT_CVT  (LAT_CVT),
    .LAT_CMP  (LAT_CMP),
    .LAT_MISC (LAT_MISC),
    .CNT_W    (CNT_W)
  ) u_lat_lut (
    .iop  (iop),
    .olat (lat)
  );

  assign accept  = (state_q == ST_IDLE) && istart;
  assign capture = (state_q == ST_BUSY) && (cnt_q == '0);
  assign retire  = (state_q == ST_DONE);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (istart)        state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == '0)   state_d = ST_DONE;
      ST_DONE:                    state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    oready = 1'b0;
    obusy  = 1'b0;
    odone  = 1'b0;
    case (state_q)
      ST_IDLE: oready = 1'b1;
      ST_BUSY: obusy  = 1'b1;
      ST_DONE: begin
        obusy = 1'b1;
        odone = 1'b1;
      end
      default: oready = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    dataa_d  = dataa_q;
    datab_d  = datab_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    comp_d   = comp_q;

    if (accept) begin
      dataa_d = ia;
      datab_d = ib;
      ctrl_d  = iop;
      cnt_d   = lat;
    end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end

    // Opcode goes back to the ALU default once the op has retired; the
    // operand registers intentionally keep their last values.
    if (retire) begin
      ctrl_d = '0;
    end

    if (capture) begin
      result_d = iresult;
      comp_d   = icompresult;
    end
  end

  // Clear first, then OR in the capturing op's flags, so a clear that lands
  // on a capture edge leaves exactly the new op's exceptions.
  always_comb begin
    flags_d = iclrflags ? 3'b000 : flags_q;
    if (capture) begin
      flags_d = flags_d | pack_flags(inan, ioverflow, iunderflow);
    end
  end

  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      cnt_q    <= '0;
      dataa_q  <= '0;
      datab_q  <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      comp_q   <= 1'b0;
      flags_q  <= 3'b000;
    end else begin
      cnt_q    <= cnt_d;
      dataa_q  <= dataa_d;
      datab_q  <= datab_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      comp_q   <= comp_d;
      flags_q  <= flags_d;
    end
  end

  assign odataa   = dataa_q;
  assign odatab   = datab_q;
  assign ocontrol = ctrl_q;
  assign oresult  = result_q;
  assign ocomp    = comp_q;
  assign offlags  = flags_q;

endmodule : fpu_issue_ctrl

// File: tb/tb_fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fpu_issue_ctrl
//
// Directed bench for the FP issue sequencer. A reference model tracks each
// operation by its accept-edge number and latency, derives every output from
// that timestamp arithmetic, and is compared against the DUT on every falling
// edge. Directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  logic        iclock = 1'b0;
  logic        ireset = 1'b1;
  logic        istart = 1'b0;
  logic [4:0]  iop = '0;
  logic [31:0] ia = '0, ib = '0, iresult = '0;
  logic        iclrflags = 1'b0;
  logic        inan = 1'b0, izero = 1'b0, ioverflow = 1'b0, iunderflow = 1'b0;
  logic        icompresult = 1'b0;

  logic [31:0] odataa, odatab, oresult;
  logic [4:0]  ocontrol;
  logic        oready, obusy, odone, ocomp;
  logic [2:0]  offlags;

  fpu_issue_ctrl dut (
    .iclock      (iclock),
    .ireset      (ireset),
    .istart      (istart),
    .iop         (iop),
    .ia          (ia),
    .ib          (ib),
    .iclrflags   (iclrflags),
    .odataa      (odataa),
    .odatab      (odatab),
    .ocontrol    (ocontrol),
    .iresult     (iresult),
    .inan        (inan),
    .izero       (izero),
    .ioverflow   (ioverflow),
    .iunderflow  (iunderflow),
    .icompresult (icompresult),
    .oready      (oready),
    .obusy       (obusy),
    .odone       (odone),
    .oresult     (oresult),
    .ocomp       (ocomp),
    .offlags     (offlags)
  );

  always #5 iclock = ~iclock;

  int n_checks    = 0;
  int n_fail      = 0;
  int done_pulses = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Latency table straight from the opcode classes.
  function automatic int lat_of(input logic [4:0] op);
    case (op)
      FOPADD, FOPSUB:                           return 7;
      FOPMUL:                                   return 5;
      FOPDIV:                                   return 6;
      FOPSQRT:                                  return 16;
      FOPCVTSW, FOPCVTWS, FOPCVTSWU, FOPCVTWUS: return 6;
      default:                                  return 1;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // An op accepted on edge A with latency L captures on edge A+L+1 (odone
  // visible after it) and retires on edge A+L+2.
  bit          m_active = 0;
  bit          m_done   = 0;
  int          m_ecnt   = 0;
  int          m_acc    = 0;
  int          m_lat    = 0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [4:0]  m_ctrl  = '0;
  logic        m_comp  = 1'b0;
  logic [2:0]  m_flags = '0;

  initial forever begin
    @(posedge iclock or posedge ireset);
    if (ireset) begin
      m_active = 0; m_done = 0; m_ecnt = 0;
      m_a = '0; m_b = '0; m_res = '0; m_ctrl = '0; m_comp = 1'b0; m_flags = '0;
    end else begin
      bit cap, fin;
      m_ecnt++;
      cap = m_active && (m_ecnt == m_acc + m_lat + 1);
      fin = m_active && (m_ecnt == m_acc + m_lat + 2);
      if (iclrflags) m_flags = 3'b000;
      if (cap) begin
        m_flags = m_flags | {inan, ioverflow, iunderflow};
        m_res   = iresult;
        m_comp  = icompresult;
      end
      if (fin) begin
        m_active = 0;
        m_ctrl   = '0;
      end else if (!m_active && istart) begin
        m_active = 1;
        m_acc    = m_ecnt;
        m_lat    = lat_of(iop);
        m_a      = ia;
        m_b      = ib;
        m_ctrl   = iop;
      end
      m_done = m_active && (m_ecnt == m_acc + m_lat + 1);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge iclock);
    check("oready",   32'(oready),   32'(!m_active));
    check("obusy",    32'(obusy),    32'(m_active));
    check("odone",    32'(odone),    32'(m_done));
    check("odataa",   odataa,        m_a);
    check("odatab",   odatab,        m_b);
    check("ocontrol", 32'(ocontrol), 32'(m_ctrl));
    check("oresult",  oresult,       m_res);
    check("ocomp",    32'(ocomp),    32'(m_comp));
    check("offlags",  32'(offlags),  32'(m_flags));
    if (odone) done_pulses++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(negedge iclock);
    #1;
  endtask

  // Issue one op with istart held for 'hold' edges, wait for odone (bounded),
  // check the edge count from the accept edge, then step past DONE.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, b, res,
                        input logic cmp, nan, ovf, unf,
                        input int hold, input int exp_edges, input string tag);
    int n;
    iop = op; ia = a; ib = b; iresult = res;
    icompresult = cmp; inan = nan; ioverflow = ovf; iunderflow = unf;
    istart = 1'b1;
    n = 0;
    repeat (hold) begin tick(); n++; end
    istart = 1'b0;
    while (!odone && n < 40) begin tick(); n++; end
    check({tag, "_latency"}, 32'(n), 32'(exp_edges));
    tick();
  endtask

  initial begin
    int d0, last, ndone;

    // Reset state
    repeat (2) tick();
    check("rst_oready",   32'(oready),   32'd1);
    check("rst_obusy",    32'(obusy),    32'd0);
    check("rst_odone",    32'(odone),    32'd0);
    check("rst_ocontrol", 32'(ocontrol), 32'd0);
    check("rst_offlags",  32'(offlags),  32'd0);
    ireset = 1'b0;
    tick();

    // FOPADD: accept E0, odone after E8 -> 9 edges observed
    run_op(FOPADD, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, 0, 1, 9, "add");
    check("add_result", oresult, 32'h40400000);
    check("add_flags",  32'(offlags), 32'd0);
    check("add_dataa",  odataa, 32'h3F800000);
    check("add_ctrl_idle", 32'(ocontrol), 32'd0);

    // FOPCLT with istart still high during BUSY: one completion only
    d0 = done_pulses;
    run_op(FOPCLT, 32'h1, 32'h2, 32'h0, 1, 0, 0, 0, 2, 3, "clt");
    repeat (4) tick();
    check("clt_comp",  32'(ocomp), 32'd1);
    check("clt_ndone", 32'(done_pulses - d0), 32'd1);

    // Sticky flag accumulation and clear
    run_op(FOPDIV, 32'h5, 32'h6, 32'h7F800000, 0, 0, 1, 0, 1, 8, "div");
    check("div_flags", 32'(offlags), 32'b010);
    run_op(FOPMUL, 32'h7, 32'h8, 32'h7FC00000, 0, 1, 0, 0, 1, 7, "mul");
    check("mul_flags", 32'(offlags), 32'b110);
    iclrflags = 1'b1; tick(); iclrflags = 1'b0;
    check("clr_flags", 32'(offlags), 32'b000);

    // Clear on the capture edge: prior 110, new op underflows -> 001
    run_op(FOPMIN, 32'h9, 32'hA, 32'hB, 0, 1, 1, 0, 1, 3, "min");
    check("min_flags", 32'(offlags), 32'b110);
    iop = FOPABS; ia = 32'hC; ib = 32'hD; iresult = 32'h00000001;
    inan = 0; ioverflow = 0; iunderflow = 1;
    istart = 1'b1; tick(); istart = 1'b0;   // E0
    tick();                                 // E1
    iclrflags = 1'b1; tick();               // E2 = capture edge
    check("clrcap_done",  32'(odone),   32'd1);
    check("clrcap_flags", 32'(offlags), 32'b001);
    iclrflags = 1'b0; tick();

    // Undefined opcode completes as a single-cycle op
    run_op(5'd31, 32'h11, 32'h22, 32'hDEADBEEF, 0, 0, 0, 0, 1, 3, "undef");
    check("undef_result", oresult, 32'hDEADBEEF);

    // FOPSQRT aborted by an asynchronous reset mid-count
    iop = FOPSQRT; ia = 32'h40800000; ib = 32'h0; iresult = 32'h40000000;
    iunderflow = 0;
    istart = 1'b1; tick(); istart = 1'b0;
    repeat (4) tick();
    d0 = done_pulses;
    #2 ireset = 1'b1;
    #1;
    check("arst_oready",   32'(oready),   32'd1);
    check("arst_obusy",    32'(obusy),    32'd0);
    check("arst_ocontrol", 32'(ocontrol), 32'd0);
    check("arst_odataa",   odataa,        32'd0);
    check("arst_oresult",  oresult,       32'd0);
    check("arst_offlags",  32'(offlags),  32'd0);
    tick();
    ireset = 1'b0;
    repeat (25) tick();
    check("arst_no_done", 32'(done_pulses - d0), 32'd0);
    check("arst_flags_kept_clear", 32'(offlags), 32'd0);
    run_op(FOPNEG, 32'h3F800000, 32'h0, 32'hBF800000, 0, 0, 0, 0, 1, 3, "neg");
    check("neg_result", oresult, 32'hBF800000);

    // Back-to-back FOPMUL with istart held high: one completion every 8
    iop = FOPMUL; iresult = 32'h12345678;
    inan = 0; ioverflow = 0; iunderflow = 0; icompresult = 0;
    istart = 1'b1;
    last = -1; ndone = 0;
    for (int i = 0; i < 50; i++) begin
      ia = 32'(i); ib = 32'(i * 3);
      tick();
      if (odone) begin
        if (last >= 0) check("b2b_period", 32'(i - last), 32'd8);
        last = i;
        ndone++;
      end
    end
    istart = 1'b0;
    check("b2b_count", 32'(ndone), 32'd6);
    repeat (12) tick();
    check("b2b_idle", 32'(oready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule : tb_fpu_issue_ctrl
